kernel_spi_slave_fifo: RTL and testbench

Parametrised SPI slave with configurable word width, SPI mode (CPOL/CPHA), bit order, and receive/transmit FIFOs, so the CPU no longer has to service every word. It sits behind the same 16-bit CPU register port as the other kernel peripherals, with an irq line and streaming flags. The SPI pins are sampled in the clk domain through synchronisers, so clk must run at least 8x the SCLK frequency.

---
 rtl/kernel_spi_slave_fifo.sv | 174 +++++++++++++++++
 tb/tb_kernel_spi_slave_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_spi_slave_fifo.sv
// SPI slave (configurable width, CPOL/CPHA, bit order) with RX/TX FIFOs behind the 16-bit kernel register port.
// SPI pins are resynchronised into clk, so clk must run at least 8x SCLK.
module kernel_spi_slave_fifo #(
  parameter int DATABITS   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int LSBFIRST   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATABITS + 1);
  localparam logic [15:0] IRQ_BITS = 16'h03D8;

  logic [1:0]          sclk_s, ss_s, mosi_s;
  logic                ck_d, ss_d, ss_sync, ck;
  logic                lead, trail, ss_fall, ss_rise, sample, shift_edge;
  logic [CW-1:0]       bit_cnt, cnt_inc;
  logic [DATABITS-1:0] tx_sh, rx_sh, rx_next, rx_head, tx_head;
  logic                word_done, load, shift_out;
  logic                rd_d, wr_d, rd_stb, wr_stb;
  logic [DATABITS-1:0] rx_mem [FIFO_DEPTH];
  logic [DATABITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]       rx_wp, rx_rp, tx_wp, tx_rp;
  logic [AW:0]         rx_cnt, tx_cnt;
  logic                rx_empty, rx_full, rx_push, rx_pop;
  logic                tx_empty, tx_full, tx_push, tx_pop, tx_wr;
  logic                roe, toe, und, status_clr;
  logic [15:0]         ctrl, status, rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s <= '0;
      ss_s   <= 2'b11;
      mosi_s <= '0;
      ck_d   <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[0], SCLK};
      ss_s   <= {ss_s[0], SS_n};
      mosi_s <= {mosi_s[0], MOSI};
      ck_d   <= ck;
      ss_d   <= ss_sync;
    end
  end

  assign ss_sync    = ss_s[1];
  assign ck         = sclk_s[1] ^ (CPOL != 0);
  assign lead       = !ss_sync && ck && !ck_d;
  assign trail      = !ss_sync && !ck && ck_d;
  assign ss_fall    = !ss_sync && ss_d;
  assign ss_rise    = ss_sync && !ss_d;
  assign sample     = (CPHA != 0) ? trail : lead;
  assign shift_edge = (CPHA != 0) ? lead : trail;

  assign cnt_inc   = bit_cnt + 1'b1;
  assign word_done = sample && (cnt_inc == CW'(DATABITS));
  // A zero count on the shift edge means a fresh word: CPHA=1 loads there, CPHA=0 must not shift.
  assign load      = (CPHA != 0) ? (lead && bit_cnt == '0) : (ss_fall || word_done);
  assign shift_out = shift_edge && bit_cnt != '0;
  assign rx_next   = (LSBFIRST != 0) ? ((rx_sh >> 1) | (DATABITS'(mosi_s[1]) << (DATABITS - 1)))
                                     : ((rx_sh << 1) | DATABITS'(mosi_s[1]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else if (ss_rise) begin
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else begin
      if (sample) begin
        rx_sh   <= rx_next;
        bit_cnt <= word_done ? '0 : cnt_inc;
      end
      if (load) tx_sh <= tx_empty ? '0 : tx_head;
      else if (shift_out) tx_sh <= (LSBFIRST != 0) ? (tx_sh >> 1) : (tx_sh << 1);
    end
  end

  assign MISO = !ss_sync && ((LSBFIRST != 0) ? tx_sh[0] : tx_sh[DATABITS-1]);

  // Register strobes fire once per access and re-arm when the access drops.
  assign rd_stb = spi_select && !read_n && !rd_d;
  assign wr_stb = spi_select && !write_n && !wr_d;

  assign rx_head  = rx_mem[rx_rp];
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == (AW+1)'(FIFO_DEPTH);
  assign rx_pop   = rd_stb && mem_addr == 3'd0 && !rx_empty;
  assign rx_push  = word_done && (!rx_full || rx_pop);

  assign tx_head  = tx_mem[tx_rp];
  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == (AW+1)'(FIFO_DEPTH);
  assign tx_pop   = load && !tx_empty;
  assign tx_wr    = wr_stb && mem_addr == 3'd1;
  assign tx_push  = tx_wr && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_next;
    if (tx_push) tx_mem[tx_wp] <= data_from_cpu[DATABITS-1:0];
  end

  assign status_clr = wr_stb && mem_addr == 3'd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_d <= 1'b0;  wr_d <= 1'b0;
      rx_wp <= '0;   rx_rp <= '0;  rx_cnt <= '0;
      tx_wp <= '0;   tx_rp <= '0;  tx_cnt <= '0;
      roe <= 1'b0;   toe <= 1'b0;  und <= 1'b0;
      ctrl <= '0;    irq <= 1'b0;  data_to_cpu <= '0;
    end else begin
      rd_d <= spi_select && !read_n;
      wr_d <= spi_select && !write_n;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      // New error events win over a same-cycle clear.
      roe <= (roe && !status_clr) || (word_done && !rx_push);
      toe <= (toe && !status_clr) || (tx_wr && !tx_push);
      und <= (und && !status_clr) || (load && tx_empty);
      if (wr_stb && mem_addr == 3'd3) ctrl <= data_from_cpu & IRQ_BITS;
      irq <= |(status & ctrl);
      if (rd_stb) data_to_cpu <= rdata;
    end
  end

  always_comb begin
    status    = '0;
    status[3] = roe;
    status[4] = toe;
    status[5] = tx_empty && ss_sync;
    status[6] = !tx_full;
    status[7] = !rx_empty;
    status[8] = roe || toe || und;
    status[9] = und;
  end

  always_comb begin
    rdata = '0;
    case (mem_addr)
      3'd0:    rdata = rx_empty ? 16'h0000 : 16'(rx_head);
      3'd2:    rdata = status;
      3'd3:    rdata = ctrl;
      3'd4:    rdata = {8'(rx_cnt), 8'(tx_cnt)};
      default: rdata = '0;
    endcase
  end

  assign dataavailable = !rx_empty;
  assign readyfordata  = !tx_full;
endmodule

// File: tb/tb_kernel_spi_slave_fifo.sv
// Bench for kernel_spi_slave_fifo: instance 0 is mode 0 MSB-first, instance 1 is mode 3 LSB-first.
module tb_kernel_spi_slave_fifo;
  localparam int HALF = 8;
  localparam int FD   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  spi_select, sclk, ss_n, irq, dav, rfd, miso;
  logic [2:0]  mem_addr;
  logic        read_n, write_n, mosi;
  logic [15:0] data_from_cpu, dout0, dout1;

  always #5 clk = ~clk;

  kernel_spi_slave_fifo #(.DATABITS(8), .FIFO_DEPTH(FD), .CPOL(0), .CPHA(0), .LSBFIRST(0)) u_m0 (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select[0]), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu), .data_to_cpu(dout0),
    .irq(irq[0]), .dataavailable(dav[0]), .readyfordata(rfd[0]),
    .SCLK(sclk[0]), .SS_n(ss_n[0]), .MOSI(mosi), .MISO(miso[0]));

  kernel_spi_slave_fifo #(.DATABITS(8), .FIFO_DEPTH(FD), .CPOL(1), .CPHA(1), .LSBFIRST(1)) u_m3 (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select[1]), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu), .data_to_cpu(dout1),
    .irq(irq[1]), .dataavailable(dav[1]), .readyfordata(rfd[1]),
    .SCLK(sclk[1]), .SS_n(ss_n[1]), .MOSI(mosi), .MISO(miso[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Reference model: plain lists per instance, head at index 0.
  logic [7:0]  m_rx [2][FD];
  logic [7:0]  m_tx [2][FD];
  int          m_rxn [2];
  int          m_txn [2];
  bit          m_roe [2], m_toe [2], m_und [2];
  logic [15:0] m_ctrl [2];
  logic [7:0]  m_cur [2];

  function automatic void m_load(input int d);
    if (m_txn[d] == 0) begin
      m_cur[d] = 8'h00;
      m_und[d] = 1'b1;
    end else begin
      m_cur[d] = m_tx[d][0];
      for (int i = 0; i < FD - 1; i++) m_tx[d][i] = m_tx[d][i+1];
      m_txn[d]--;
    end
  endfunction

  function automatic void m_push_rx(input int d, input logic [7:0] w);
    if (m_rxn[d] < FD) begin m_rx[d][m_rxn[d]] = w; m_rxn[d]++; end
    else m_roe[d] = 1'b1;
  endfunction

  function automatic void m_push_tx(input int d, input logic [7:0] w);
    if (m_txn[d] < FD) begin m_tx[d][m_txn[d]] = w; m_txn[d]++; end
    else m_toe[d] = 1'b1;
  endfunction

  function automatic logic [7:0] m_pop_rx(input int d);
    logic [7:0] v;
    if (m_rxn[d] == 0) return 8'h00;
    v = m_rx[d][0];
    for (int i = 0; i < FD - 1; i++) m_rx[d][i] = m_rx[d][i+1];
    m_rxn[d]--;
    return v;
  endfunction

  function automatic logic [15:0] m_status(input int d);
    logic [15:0] s;
    s    = '0;
    s[3] = m_roe[d];
    s[4] = m_toe[d];
    s[5] = (m_txn[d] == 0) && ss_n[d];
    s[6] = m_txn[d] < FD;
    s[7] = m_rxn[d] != 0;
    s[8] = m_roe[d] | m_toe[d] | m_und[d];
    s[9] = m_und[d];
    return s;
  endfunction

  function automatic void m_clr(input int d);
    m_roe[d] = 1'b0; m_toe[d] = 1'b0; m_und[d] = 1'b0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input int d, input logic [2:0] a, input logic [15:0] v);
    mem_addr = a; data_from_cpu = v; spi_select[d] = 1'b1; write_n = 1'b0;
    cyc(1);
    spi_select[d] = 1'b0; write_n = 1'b1;
    cyc(1);
  endtask

  task automatic cpu_rd(input int d, input logic [2:0] a, output logic [15:0] v);
    mem_addr = a; spi_select[d] = 1'b1; read_n = 1'b0;
    cyc(1);
    v = (d == 0) ? dout0 : dout1;
    spi_select[d] = 1'b0; read_n = 1'b1;
    cyc(1);
  endtask

  task automatic tx_write(input int d, input logic [15:0] v);
    cpu_wr(d, 3'd1, v);
    m_push_tx(d, v[7:0]);
  endtask

  task automatic rx_read(input int d, input string tag, output logic [15:0] v);
    cpu_rd(d, 3'd0, v);
    check(tag, v, {8'h00, m_pop_rx(d)});
  endtask

  task automatic ss_low(input int d);
    ss_n[d] = 1'b0;
    cyc(HALF);
    if (d == 0) m_load(0);
  endtask

  task automatic ss_high(input int d);
    ss_n[d] = 1'b1;
    cyc(HALF);
  endtask

  // One master word (or nb<8 bits of one); MISO checked just before each sample edge.
  task automatic spi_bits(input int d, input logic [7:0] w, input int nb, input string tag);
    logic [7:0] exp_tx;
    int idx;
    if (d == 1) m_load(1);
    exp_tx = m_cur[d];
    for (int i = 0; i < nb; i++) begin
      idx = (d == 1) ? i : 7 - i;
      if (d == 0) begin
        mosi = w[idx];
        cyc(HALF);
        check(tag, 16'(miso[0]), 16'(exp_tx[idx]));
        sclk[0] = 1'b1;
        cyc(HALF);
        sclk[0] = 1'b0;
      end else begin
        sclk[1] = 1'b0;
        mosi = w[idx];
        cyc(HALF);
        check(tag, 16'(miso[1]), 16'(exp_tx[idx]));
        sclk[1] = 1'b1;
        cyc(HALF);
      end
    end
    if (d == 0) cyc(HALF);
    if (nb == 8) begin
      m_push_rx(d, w);
      if (d == 0) m_load(0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int d, op, nw;
    for (int i = 0; i < 2; i++) begin
      m_rxn[i] = 0; m_txn[i] = 0; m_ctrl[i] = '0; m_cur[i] = '0;
      m_roe[i] = 0; m_toe[i] = 0; m_und[i] = 0;
    end
    reset_n = 1'b0; spi_select = '0; read_n = 1'b1; write_n = 1'b1;
    mem_addr = '0; data_from_cpu = '0; mosi = 1'b0;
    ss_n = 2'b11; sclk = 2'b10;
    cyc(3);
    reset_n = 1'b1;
    cyc(3);

    for (int i = 0; i < 2; i++) begin
      check("rst_dout", (i == 0) ? dout0 : dout1, 16'h0000);
      check("rst_irq", 16'(irq[i]), 16'h0);
      check("rst_dav", 16'(dav[i]), 16'h0);
      check("rst_rfd", 16'(rfd[i]), 16'h1);
      check("rst_miso", 16'(miso[i]), 16'h0);
      cpu_rd(i, 3'd2, v);
      check("rst_status", v, 16'h0060);
    end

    // Mode 0: TX 0xA5 out while 0x3C comes in.
    tx_write(0, 16'h00A5);
    ss_low(0);
    spi_bits(0, 8'h3C, 8, "t2_miso");
    ss_high(0);
    rx_read(0, "t2_rx_model", v);
    check("t2_rx", v, 16'h003C);
    cpu_rd(0, 3'd2, v);
    check("t2_rrdy", 16'(v[7]), 16'h0);
    check("t2_status", v, m_status(0));
    cpu_wr(0, 3'd2, 16'h0000); m_clr(0);

    // RX overrun with five words and no reads.
    ss_low(0);
    for (int k = 0; k < 5; k++) spi_bits(0, 8'(8'h10 + k), 8, "t3_miso");
    ss_high(0);
    cpu_rd(0, 3'd4, v);
    check("t3_levels", v, 16'h0400);
    cpu_rd(0, 3'd2, v);
    check("t3_roe", 16'(v[3]), 16'h1);
    check("t3_status", v, m_status(0));
    for (int k = 0; k < 4; k++) begin
      rx_read(0, "t3_rx_model", v);
      check("t3_rx", v, 16'(8'h10 + k));
    end
    cpu_wr(0, 3'd2, 16'hFFFF); m_clr(0);
    cpu_rd(0, 3'd2, v);
    check("t3_roe_clr", 16'(v[3]), 16'h0);

    // Mode 3, LSB first.
    tx_write(1, 16'h0001);
    ss_low(1);
    spi_bits(1, 8'h80, 8, "t4_miso");
    ss_high(1);
    rx_read(1, "t4_rx_model", v);
    check("t4_rx", v, 16'h0080);

    // Underflow with irq enabled on UND.
    cpu_wr(0, 3'd3, 16'h0200); m_ctrl[0] = 16'h0200;
    check("t5_irq_idle", 16'(irq[0]), 16'h0);
    ss_n[0] = 1'b0;
    cyc(2);
    check("t5_irq_early", 16'(irq[0]), 16'h0);
    cyc(4);
    check("t5_irq_set", 16'(irq[0]), 16'h1);
    cyc(HALF - 6);
    m_load(0);
    spi_bits(0, 8'h6E, 8, "t5_miso");
    ss_high(0);
    cpu_rd(0, 3'd2, v);
    check("t5_und", 16'(v[9]), 16'h1);
    check("t5_status", v, m_status(0));
    rx_read(0, "t5_rx", v);
    cpu_wr(0, 3'd2, 16'h0000); m_clr(0);
    cyc(2);
    check("t5_irq_clr", 16'(irq[0]), 16'h0);
    cpu_wr(0, 3'd3, 16'h0000); m_ctrl[0] = 16'h0000;

    // Abort after 3 bits, then a full word.
    tx_write(1, 16'h005A);
    ss_low(1);
    spi_bits(1, 8'hFF, 3, "t6_miso");
    ss_high(1);
    cpu_rd(1, 3'd4, v);
    check("t6_levels", v, 16'h0000);
    ss_low(1);
    spi_bits(1, 8'hC6, 8, "t6_miso2");
    ss_high(1);
    rx_read(1, "t6_rx_model", v);
    check("t6_rx", v, 16'h00C6);
    cpu_wr(1, 3'd2, 16'h0000); m_clr(1);

    // TX overflow sets TOE.
    for (int k = 0; k < FD + 1; k++) tx_write(0, 16'(16'h0120 + k));
    cpu_rd(0, 3'd2, v);
    check("t7_toe", 16'(v[4]), 16'h1);
    check("t7_status", v, m_status(0));

    for (int it = 0; it < 60; it++) begin
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 5));
      case (op)
        0: tx_write(d, 16'($urandom));
        1: rx_read(d, "r_rx", v);
        2: begin
          ss_low(d);
          nw = int'($urandom_range(1, 2));
          for (int k = 0; k < nw; k++) spi_bits(d, 8'($urandom), 8, "r_miso");
          if ($urandom_range(0, 3) == 0) spi_bits(d, 8'($urandom), int'($urandom_range(1, 7)), "r_miso_part");
          ss_high(d);
        end
        3: begin
          cpu_rd(d, 3'd2, v);
          check("r_status", v, m_status(d));
        end
        4: begin
          cpu_rd(d, 3'd4, v);
          check("r_levels", v, {8'(m_rxn[d]), 8'(m_txn[d])});
        end
        default: begin
          cpu_wr(d, 3'd2, 16'($urandom));
          m_clr(d);
        end
      endcase
      check("r_dav", 16'(dav[d]), 16'(m_rxn[d] != 0));
      check("r_rfd", 16'(rfd[d]), 16'(m_txn[d] < FD));
      check("r_irq", 16'(irq[d]), 16'(|(m_status(d) & m_ctrl[d])));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
